// File: rtl/delay_line_ctrl_if.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl_if
//   Bundles the sample stream and the delay-configuration handshake of the
//   programmable delay line.
//
//   master : producer/consumer/software side (drives samples and config)
//   slave  : the delay line itself
//
//   data_i / data_vld_i   input sample and its valid (taken when in_ready=1)
//   in_ready              line accepts input samples
//   data_o / data_vld_o   delayed sample and its valid
//   cfg_valid / cfg_dly   delay change request / requested delay
//   cfg_ready             config can be accepted
//   cfg_err               one-cycle pulse for a rejected config
//   cur_dly               delay currently in effect
//   busy                  drain in progress
// ---------------------------------------------------------------------------
interface delay_line_ctrl_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_DLY = 16
);
  localparam int CW = $clog2(MAX_DLY + 1);

  logic [WIDTH-1:0] data_i;
  logic             data_vld_i;
  logic             in_ready;
  logic [WIDTH-1:0] data_o;
  logic             data_vld_o;
  logic             cfg_valid;
  logic [CW-1:0]    cfg_dly;
  logic             cfg_ready;
  logic             cfg_err;
  logic [CW-1:0]    cur_dly;
  logic             busy;

  modport master (
    output data_i, data_vld_i, cfg_valid, cfg_dly,
    input  in_ready, data_o, data_vld_o, cfg_ready, cfg_err, cur_dly, busy
  );

  modport slave (
    input  data_i, data_vld_i, cfg_valid, cfg_dly,
    output in_ready, data_o, data_vld_o, cfg_ready, cfg_err, cur_dly, busy
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl
//   Runtime-programmable delay line. A shift register of MAX_DLY stages is
//   tapped at stage cur_dly-1, giving a latency of exactly cur_dly cycles.
//   A delay change is accepted over a valid/ready handshake; the line is then
//   drained at the old delay (bubbles shifted in, input stalled) before the
//   new delay takes effect, so no in-flight sample is lost or repeated.
//
//   Ports
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     bus     delay_line_ctrl_if.slave: sample stream, config handshake,
//             cfg_err, cur_dly, busy
// ---------------------------------------------------------------------------
module delay_line_ctrl #(
  parameter int WIDTH   = 8,
  parameter int MAX_DLY = 16,
  parameter int DEF_DLY = 3
) (
  input logic             clk,
  input logic             rst_n,
  delay_line_ctrl_if.slave bus
);

  localparam int CW = $clog2(MAX_DLY + 1);
  localparam int AW = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cur_dly_q, cur_dly_d;
  logic [CW-1:0]    pend_dly_q, pend_dly_d;
  logic [CW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q;
  logic             flush;
  logic             cfg_legal;
  logic             run;

  logic [MAX_DLY-1:0] stage_vld_q;
  logic [WIDTH-1:0]   stage_data_q [MAX_DLY];
  logic [AW-1:0]      tap;

  assign run       = (state_q == RUN);
  assign cfg_legal = (bus.cfg_dly != '0) && (bus.cfg_dly <= CW'(MAX_DLY));

  // -------------------------------------------------------------------------
  // Controller: next state and register updates
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    cur_dly_d   = cur_dly_q;
    pend_dly_d  = pend_dly_q;
    drain_cnt_d = drain_cnt_q;
    cfg_err_d   = 1'b0;
    flush       = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.cfg_valid) begin
          if (cfg_legal) begin
            pend_dly_d  = bus.cfg_dly;
            drain_cnt_d = cur_dly_q;
            state_d     = DRAIN;
          end else begin
            // Handshake completes; request is dropped and flagged.
            cfg_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == CW'(1)) begin
          cur_dly_d = pend_dly_q;
          state_d   = RUN;
          // The last in-flight sample is on the tap this cycle. Clearing the
          // whole line at the switch keeps a longer new delay from exposing
          // samples that already left through the old tap.
          flush     = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cur_dly_q   <= CW'(DEF_DLY);
      pend_dly_q  <= CW'(DEF_DLY);
      drain_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dly_q   <= cur_dly_d;
      pend_dly_q  <= pend_dly_d;
      drain_cnt_q <= drain_cnt_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= (state_d == DRAIN);
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: shift register, bubbles enter whenever input is stalled
  // -------------------------------------------------------------------------
  // NOTE: the stage array is reset (unlike a plain RAM) because downstream
  // relies on the line holding only bubbles after reset or a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld_q <= '0;
      for (int k = 0; k < MAX_DLY; k++) stage_data_q[k] <= '0;
    end else if (flush) begin
      stage_vld_q <= '0;
      for (int k = 0; k < MAX_DLY; k++) stage_data_q[k] <= '0;
    end else begin
      stage_vld_q[0]  <= bus.data_vld_i & run;
      stage_data_q[0] <= run ? bus.data_i : '0;
      for (int k = 1; k < MAX_DLY; k++) begin
        stage_vld_q[k]  <= stage_vld_q[k-1];
        stage_data_q[k] <= stage_data_q[k-1];
      end
    end
  end

  assign tap = AW'(cur_dly_q - CW'(1));

  assign bus.data_o     = stage_data_q[tap];
  assign bus.data_vld_o = stage_vld_q[tap];
  assign bus.in_ready   = run;
  assign bus.cfg_ready  = run;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.cur_dly    = cur_dly_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_line_ctrl
//   Self-checking bench for delay_line_ctrl. A reference model tracks, in
//   cycle numbers, when each accepted sample must leave the line and when a
//   delay change takes effect; every cycle the DUT outputs are compared to it.
//   Scenario tasks add their own targeted comparisons.
// ---------------------------------------------------------------------------
module tb_delay_line_ctrl;

  localparam int WIDTH   = 8;
  localparam int MAX_DLY = 16;
  localparam int DEF_DLY = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  delay_line_ctrl_if #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY)) bus ();

  delay_line_ctrl #(
    .WIDTH  (WIDTH),
    .MAX_DLY(MAX_DLY),
    .DEF_DLY(DEF_DLY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: cycle-indexed expectations
  int         m_cur;
  bit         m_pend;
  int         m_next;
  int         m_sw_cyc;
  int         m_err_cyc;
  bit         exp_vld [int];
  logic [7:0] exp_dat [int];

  // Outputs observed at the start of the most recent tick
  int         obs_cyc;
  logic       obs_vld, obs_rdy, obs_cfg_rdy, obs_busy, obs_err;
  logic [7:0] obs_dat;
  logic [4:0] obs_cur;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    m_cur     = DEF_DLY;
    m_pend    = 1'b0;
    m_next    = DEF_DLY;
    m_sw_cyc  = 0;
    m_err_cyc = -1;
    exp_vld.delete();
    exp_dat.delete();
  endtask

  // One clock cycle: compare current outputs with the model, drive inputs,
  // let the model account for what the line accepts, then advance.
  task automatic tick(input bit vld, input logic [7:0] d, input bit cv, input int cd);
    bit         e_vld, e_busy, e_err;
    logic [7:0] e_dat;
    if (m_pend && cyc >= m_sw_cyc) begin
      m_cur  = m_next;
      m_pend = 1'b0;
    end
    e_busy = m_pend;
    e_err  = (cyc == m_err_cyc);
    e_vld  = exp_vld.exists(cyc);
    e_dat  = e_vld ? exp_dat[cyc] : 8'h00;

    obs_cyc     = cyc;
    obs_vld     = bus.data_vld_o;
    obs_dat     = bus.data_o;
    obs_rdy     = bus.in_ready;
    obs_cfg_rdy = bus.cfg_ready;
    obs_busy    = bus.busy;
    obs_err     = bus.cfg_err;
    obs_cur     = bus.cur_dly;

    n_cmp++;
    if (obs_rdy !== !e_busy) begin
      n_bad++;
      $display("FAIL in_ready @%0d: got %b expected %b", cyc, obs_rdy, !e_busy);
    end
    n_cmp++;
    if (obs_cfg_rdy !== !e_busy) begin
      n_bad++;
      $display("FAIL cfg_ready @%0d: got %b expected %b", cyc, obs_cfg_rdy, !e_busy);
    end
    n_cmp++;
    if (obs_busy !== e_busy) begin
      n_bad++;
      $display("FAIL busy @%0d: got %b expected %b", cyc, obs_busy, e_busy);
    end
    n_cmp++;
    if (obs_cur !== 5'(m_cur)) begin
      n_bad++;
      $display("FAIL cur_dly @%0d: got %0d expected %0d", cyc, obs_cur, m_cur);
    end
    n_cmp++;
    if (obs_err !== e_err) begin
      n_bad++;
      $display("FAIL cfg_err @%0d: got %b expected %b", cyc, obs_err, e_err);
    end
    n_cmp++;
    if (obs_vld !== e_vld) begin
      n_bad++;
      $display("FAIL data_vld_o @%0d: got %b expected %b", cyc, obs_vld, e_vld);
    end
    if (e_vld) begin
      n_cmp++;
      if (obs_dat !== e_dat) begin
        n_bad++;
        $display("FAIL data_o @%0d: got %02h expected %02h", cyc, obs_dat, e_dat);
      end
    end

    bus.data_vld_i = vld;
    bus.data_i     = d;
    bus.cfg_valid  = cv;
    bus.cfg_dly    = 5'(cd);

    if (!m_pend) begin
      if (vld) begin
        exp_vld[cyc + m_cur] = 1'b1;
        exp_dat[cyc + m_cur] = d;
      end
      if (cv) begin
        if (cd >= 1 && cd <= MAX_DLY) begin
          m_pend   = 1'b1;
          m_next   = cd;
          m_sw_cyc = cyc + m_cur + 1;
        end else begin
          m_err_cyc = cyc + 1;
        end
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 0);
  endtask

  task automatic test_reset();
    int         c0, first_out;
    logic [7:0] got [$];
    rst_n          = 1'b0;
    bus.data_i     = '0;
    bus.data_vld_i = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_dly    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    n_cmp++; if (bus.in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (bus.cfg_ready !== 1'b1)  begin n_bad++; $display("FAIL reset cfg_ready: got %b expected 1", bus.cfg_ready); end
    n_cmp++; if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.cfg_err !== 1'b0)    begin n_bad++; $display("FAIL reset cfg_err: got %b expected 0", bus.cfg_err); end
    n_cmp++; if (bus.data_vld_o !== 1'b0) begin n_bad++; $display("FAIL reset data_vld_o: got %b expected 0", bus.data_vld_o); end
    n_cmp++; if (bus.data_o !== 8'h00)    begin n_bad++; $display("FAIL reset data_o: got %02h expected 00", bus.data_o); end
    n_cmp++; if (bus.cur_dly !== 5'(DEF_DLY)) begin n_bad++; $display("FAIL reset cur_dly: got %0d expected %0d", bus.cur_dly, DEF_DLY); end

    tick(1'b1, 8'h11, 1'b0, 0);
    c0 = obs_cyc;
    tick(1'b1, 8'h22, 1'b0, 0);
    tick(1'b1, 8'h33, 1'b0, 0);
    first_out = -1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 1'b0, 0);
      if (obs_vld) begin
        if (first_out < 0) first_out = obs_cyc;
        got.push_back(obs_dat);
      end
    end
    n_cmp++;
    if (first_out - c0 != DEF_DLY) begin
      n_bad++;
      $display("FAIL reset latency: got %0d expected %0d", first_out - c0, DEF_DLY);
    end
    n_cmp++;
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      n_bad++;
      $display("FAIL reset order: got %0d samples expected 11 22 33", got.size());
    end
  endtask

  task automatic test_grow();
    int c_acc, a5_cyc, busy_n, nrdy_n, c5, lat;
    tick(1'b1, 8'hA5, 1'b1, 7);
    c_acc  = obs_cyc;
    a5_cyc = -1;
    busy_n = 0;
    nrdy_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'h00, 1'b0, 0);
      if (obs_busy) busy_n++;
      if (!obs_rdy) nrdy_n++;
      if (obs_vld && obs_dat == 8'hA5 && a5_cyc < 0) a5_cyc = obs_cyc;
    end
    n_cmp++; if (busy_n != 3) begin n_bad++; $display("FAIL grow busy cycles: got %0d expected 3", busy_n); end
    n_cmp++; if (nrdy_n != 3) begin n_bad++; $display("FAIL grow stall cycles: got %0d expected 3", nrdy_n); end
    n_cmp++; if (a5_cyc - c_acc != 3) begin n_bad++; $display("FAIL grow A5 latency: got %0d expected 3", a5_cyc - c_acc); end
    n_cmp++; if (obs_cur !== 5'd7) begin n_bad++; $display("FAIL grow cur_dly: got %0d expected 7", obs_cur); end

    tick(1'b1, 8'h5A, 1'b0, 0);
    c5  = obs_cyc;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 8'h00, 1'b0, 0);
      if (obs_vld && obs_dat == 8'h5A && lat < 0) lat = obs_cyc - c5;
    end
    n_cmp++; if (lat != 7) begin n_bad++; $display("FAIL grow 5A latency: got %0d expected 7", lat); end
  endtask

  task automatic test_cfg_err();
    int err_n, busy_n;
    err_n  = 0;
    busy_n = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1'($urandom_range(0, 1)), 8'($urandom), (i == 3) || (i == 8), (i == 3) ? 0 : MAX_DLY + 1);
      if (obs_err)  err_n++;
      if (obs_busy) busy_n++;
    end
    n_cmp++; if (err_n != 2)  begin n_bad++; $display("FAIL cfg_err pulses: got %0d expected 2", err_n); end
    n_cmp++; if (busy_n != 0) begin n_bad++; $display("FAIL cfg_err busy: got %0d expected 0", busy_n); end
    n_cmp++; if (obs_cur !== 5'd7) begin n_bad++; $display("FAIL cfg_err cur_dly: got %0d expected 7", obs_cur); end
  endtask

  task automatic test_held_cfg();
    int held, busy_n;
    tick(1'b0, 8'h00, 1'b1, 5);
    held = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 8'h00, 1'b1, 2);
      held++;
      if (obs_cfg_rdy) break;
    end
    n_cmp++; if (held != 8) begin n_bad++; $display("FAIL held cfg accept cycle: got %0d expected 8", held); end
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 8'h00, 1'b0, 0);
      if (obs_busy) busy_n++;
    end
    n_cmp++; if (busy_n != 5) begin n_bad++; $display("FAIL held cfg drain cycles: got %0d expected 5", busy_n); end
    n_cmp++; if (obs_cur !== 5'd2) begin n_bad++; $display("FAIL held cfg cur_dly: got %0d expected 2", obs_cur); end
  endtask

  task automatic test_shrink();
    logic [7:0] sent [$];
    logic [7:0] got  [$];
    logic [7:0] d;
    int         busy_n, c;
    bit         order_ok;
    tick(1'b0, 8'h00, 1'b1, MAX_DLY);
    idle(5);
    busy_n = 0;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(1, 255));
      sent.push_back(d);
      tick(1'b1, d, i == 15, 1);
      if (obs_vld) got.push_back(obs_dat);
    end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 8'h00, 1'b0, 0);
      if (obs_vld)  got.push_back(obs_dat);
      if (obs_busy) busy_n++;
    end
    n_cmp++; if (got.size() != 16) begin n_bad++; $display("FAIL shrink sample count: got %0d expected 16", got.size()); end
    order_ok = (got.size() == 16);
    for (int i = 0; i < 16 && i < got.size(); i++) if (got[i] !== sent[i]) order_ok = 1'b0;
    n_cmp++; if (!order_ok) begin n_bad++; $display("FAIL shrink order: got %b expected 1", order_ok); end
    n_cmp++; if (busy_n != 16) begin n_bad++; $display("FAIL shrink drain cycles: got %0d expected 16", busy_n); end
    tick(1'b1, 8'h3C, 1'b0, 0);
    c = obs_cyc;
    tick(1'b0, 8'h00, 1'b0, 0);
    n_cmp++;
    if (!(obs_vld === 1'b1 && obs_dat === 8'h3C && obs_cyc - c == 1)) begin
      n_bad++;
      $display("FAIL shrink 1-cycle latency: got vld=%b data=%02h expected vld=1 data=3c", obs_vld, obs_dat);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_drain();
    tick(1'b0, 8'h00, 1'b1, 9);
    idle(3);
    for (int i = 0; i < 4; i++) tick(1'b1, 8'($urandom), 1'b0, 0);
    tick(1'b1, 8'h77, 1'b1, 4);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.data_vld_o !== 1'b0) begin n_bad++; $display("FAIL mid-drain reset data_vld_o: got %b expected 0", bus.data_vld_o); end
    n_cmp++; if (bus.cur_dly !== 5'(DEF_DLY)) begin n_bad++; $display("FAIL mid-drain reset cur_dly: got %0d expected %0d", bus.cur_dly, DEF_DLY); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid-drain reset busy: got %b expected 0", bus.busy); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_bad++; $display("FAIL post-reset in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL post-reset cfg_ready: got %b expected 1", bus.cfg_ready); end
    for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 1'b0, 0);
    idle(6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, MAX_DLY + 4));
    end
    idle(2 * MAX_DLY + 4);
  endtask

  initial begin
    test_reset();
    test_grow();
    test_cfg_err();
    test_held_cfg();
    test_shrink();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
